// File: rtl/proc_mem_arbiter.sv
// Two-requester memory arbiter: round-robin merge of data/instruction requests,
// in-order response routing through a FIFO of requester IDs (0 = data, 1 = instruction).
module proc_mem_arbiter #(
    parameter int REQ_W    = 67,
    parameter int RESP_W   = 47,
    parameter int MAX_OUTS = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              dreq_val,
    output logic              dreq_rdy,
    input  logic [REQ_W-1:0]  dreq_msg,

    input  logic              ireq_val,
    output logic              ireq_rdy,
    input  logic [REQ_W-1:0]  ireq_msg,

    output logic              memreq_val,
    input  logic              memreq_rdy,
    output logic [REQ_W-1:0]  memreq_msg,

    input  logic              memresp_val,
    output logic              memresp_rdy,
    input  logic [RESP_W-1:0] memresp_msg,

    output logic              dresp_val,
    input  logic              dresp_rdy,
    output logic [RESP_W-1:0] dresp_msg,

    output logic              iresp_val,
    input  logic              iresp_rdy,
    output logic [RESP_W-1:0] iresp_msg
);
    localparam int PTR_W = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTS);

    logic                prio;
    logic                lock_v;
    logic                lock_id;
    logic [MAX_OUTS-1:0] tag_q;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;

    logic grant_v;
    logic grant_id;
    logic grant_val;
    logic has_room;
    logic memreq_fire;
    logic memresp_fire;
    logic resp_busy;
    logic head_id;

    // A held grant keeps memreq_msg stable while memory applies backpressure.
    always_comb begin
        grant_v  = 1'b0;
        grant_id = 1'b0;
        if (lock_v) begin
            grant_v  = 1'b1;
            grant_id = lock_id;
        end else if (dreq_val && ireq_val) begin
            grant_v  = 1'b1;
            grant_id = prio;
        end else if (dreq_val) begin
            grant_v  = 1'b1;
            grant_id = 1'b0;
        end else if (ireq_val) begin
            grant_v  = 1'b1;
            grant_id = 1'b1;
        end
    end

    assign has_room    = (count != FULL_CNT);
    assign grant_val   = grant_id ? ireq_val : dreq_val;
    assign memreq_val  = grant_v && grant_val && has_room;
    assign memreq_msg  = grant_id ? ireq_msg : dreq_msg;
    assign dreq_rdy    = grant_v && !grant_id && memreq_rdy && has_room;
    assign ireq_rdy    = grant_v && grant_id && memreq_rdy && has_room;
    assign memreq_fire = memreq_val && memreq_rdy;

    assign resp_busy    = (count != '0);
    assign head_id      = tag_q[head];
    assign dresp_val    = resp_busy && !head_id && memresp_val;
    assign iresp_val    = resp_busy && head_id && memresp_val;
    assign memresp_rdy  = resp_busy && (head_id ? iresp_rdy : dresp_rdy);
    assign memresp_fire = memresp_val && memresp_rdy;
    assign dresp_msg    = memresp_msg;
    assign iresp_msg    = memresp_msg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio    <= 1'b0;
            lock_v  <= 1'b0;
            lock_id <= 1'b0;
            tag_q   <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (memreq_fire) begin
                lock_v      <= 1'b0;
                prio        <= !grant_id;
                tag_q[tail] <= grant_id;
                tail        <= tail + 1'b1;
            end else if (memreq_val) begin
                lock_v  <= 1'b1;
                lock_id <= grant_id;
            end
            if (memresp_fire) begin
                head <= head + 1'b1;
            end
            case ({memreq_fire, memresp_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A response with nothing outstanding means memory and arbiter disagree on ordering.
    assert property (@(posedge clk) disable iff (!reset) !(memresp_val && (count == '0)));

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Self-checking bench for proc_mem_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the arbitration and routing rules.
module tb_proc_mem_arbiter;
    localparam int REQ_W    = 67;
    localparam int RESP_W   = 47;
    localparam int MAX_OUTS = 4;

    logic              clk;
    logic              reset;
    logic              dreq_val, dreq_rdy;
    logic [REQ_W-1:0]  dreq_msg;
    logic              ireq_val, ireq_rdy;
    logic [REQ_W-1:0]  ireq_msg;
    logic              memreq_val, memreq_rdy;
    logic [REQ_W-1:0]  memreq_msg;
    logic              memresp_val, memresp_rdy;
    logic [RESP_W-1:0] memresp_msg;
    logic              dresp_val, dresp_rdy;
    logic [RESP_W-1:0] dresp_msg;
    logic              iresp_val, iresp_rdy;
    logic [RESP_W-1:0] iresp_msg;

    int n_checks = 0;
    int n_errors = 0;

    proc_mem_arbiter #(.REQ_W(REQ_W), .RESP_W(RESP_W), .MAX_OUTS(MAX_OUTS)) dut (
        .clk(clk), .reset(reset),
        .dreq_val(dreq_val), .dreq_rdy(dreq_rdy), .dreq_msg(dreq_msg),
        .ireq_val(ireq_val), .ireq_rdy(ireq_rdy), .ireq_msg(ireq_msg),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
        .dresp_val(dresp_val), .dresp_rdy(dresp_rdy), .dresp_msg(dresp_msg),
        .iresp_val(iresp_val), .iresp_rdy(iresp_rdy), .iresp_msg(iresp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // Reference model: owner queue of outstanding requests plus fairness and hold state.
    bit tags[$];
    bit m_prio, m_lock_v, m_lock_id;
    bit e_gv, e_gid, e_memreq_val, e_drdy, e_irdy, e_memresp_rdy, e_dv, e_iv;
    bit e_req_fire, e_resp_fire;
    bit last_req_fire, last_gid;

    function automatic void model_eval();
        bit room;
        bit gval;
        e_gv  = 1'b0;
        e_gid = 1'b0;
        if (m_lock_v) begin
            e_gv = 1'b1; e_gid = m_lock_id;
        end else if (dreq_val && ireq_val) begin
            e_gv = 1'b1; e_gid = m_prio;
        end else if (dreq_val) begin
            e_gv = 1'b1; e_gid = 1'b0;
        end else if (ireq_val) begin
            e_gv = 1'b1; e_gid = 1'b1;
        end
        room = (tags.size() < MAX_OUTS);
        gval = e_gid ? ireq_val : dreq_val;
        e_memreq_val = e_gv && gval && room;
        e_drdy = e_gv && !e_gid && memreq_rdy && room;
        e_irdy = e_gv && e_gid && memreq_rdy && room;
        if (tags.size() == 0) begin
            e_memresp_rdy = 1'b0; e_dv = 1'b0; e_iv = 1'b0;
        end else begin
            e_dv = !tags[0] && memresp_val;
            e_iv = tags[0] && memresp_val;
            e_memresp_rdy = tags[0] ? iresp_rdy : dresp_rdy;
        end
        e_req_fire  = e_memreq_val && memreq_rdy;
        e_resp_fire = memresp_val && e_memresp_rdy;
    endfunction

    task automatic advance();
        bit rf, pf, gid, stall, rst;
        model_eval();
        rf = e_req_fire; pf = e_resp_fire; gid = e_gid;
        stall = e_memreq_val && !memreq_rdy;
        rst = !reset;
        @(posedge clk);
        if (rst) begin
            tags.delete(); m_prio = 1'b0; m_lock_v = 1'b0; m_lock_id = 1'b0;
        end else begin
            if (pf) void'(tags.pop_front());
            if (rf) begin
                tags.push_back(gid); m_prio = !gid; m_lock_v = 1'b0;
            end else if (stall) begin
                m_lock_v = 1'b1; m_lock_id = gid;
            end
        end
        last_req_fire = rf && !rst;
        last_gid = gid;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        dreq_val = 1'b0; ireq_val = 1'b0; dreq_msg = '0; ireq_msg = '0;
        memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_msg = '0;
        dresp_rdy = 1'b0; iresp_rdy = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        advance();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        advance();
        advance();
        #1;
        n_checks++; if (memreq_val !== 1'b0) begin n_errors++; $display("FAIL rst_memreq_val: got %0b want 0", memreq_val); end
        n_checks++; if (dreq_rdy !== 1'b0) begin n_errors++; $display("FAIL rst_dreq_rdy: got %0b want 0", dreq_rdy); end
        n_checks++; if (ireq_rdy !== 1'b0) begin n_errors++; $display("FAIL rst_ireq_rdy: got %0b want 0", ireq_rdy); end
        dresp_rdy = 1'b1; iresp_rdy = 1'b1;
        #1;
        n_checks++; if (memresp_rdy !== 1'b0) begin n_errors++; $display("FAIL rst_memresp_rdy: got %0b want 0", memresp_rdy); end
        n_checks++; if (dresp_val !== 1'b0 || iresp_val !== 1'b0) begin n_errors++; $display("FAIL rst_resp_val: got d=%0b i=%0b want 0 0", dresp_val, iresp_val); end
        reset = 1'b1;
        #1;
        n_checks++; if (memresp_rdy !== 1'b0) begin n_errors++; $display("FAIL post_rst_memresp_rdy: got %0b want 0", memresp_rdy); end
        n_checks++; if (memreq_val !== 1'b0) begin n_errors++; $display("FAIL post_rst_memreq_val: got %0b want 0", memreq_val); end
        advance();
    endtask

    task automatic test_single_port();
        do_reset();
        dreq_val = 1'b1; dreq_msg = 67'h11; memreq_rdy = 1'b1; dresp_rdy = 1'b1;
        #1;
        n_checks++; if (memreq_val !== 1'b1) begin n_errors++; $display("FAIL single_memreq_val: got %0b want 1", memreq_val); end
        n_checks++; if (memreq_msg !== 67'h11) begin n_errors++; $display("FAIL single_memreq_msg: got %0h want 11", memreq_msg); end
        n_checks++; if (dreq_rdy !== 1'b1 || ireq_rdy !== 1'b0) begin n_errors++; $display("FAIL single_rdy: got d=%0b i=%0b want 1 0", dreq_rdy, ireq_rdy); end
        advance();
        dreq_val = 1'b0; memresp_val = 1'b1; memresp_msg = 47'hAA;
        #1;
        n_checks++; if (dresp_val !== 1'b1 || dresp_msg !== 47'hAA) begin n_errors++; $display("FAIL single_dresp: got val=%0b msg=%0h want 1 aa", dresp_val, dresp_msg); end
        n_checks++; if (iresp_val !== 1'b0) begin n_errors++; $display("FAIL single_iresp_val: got %0b want 0", iresp_val); end
        n_checks++; if (memresp_rdy !== 1'b1) begin n_errors++; $display("FAIL single_memresp_rdy: got %0b want 1", memresp_rdy); end
        advance();
        memresp_val = 1'b0;
        #1;
        n_checks++; if (memresp_rdy !== 1'b0) begin n_errors++; $display("FAIL single_drained: memresp_rdy got %0b want 0", memresp_rdy); end
        advance();
    endtask

    task automatic test_round_robin();
        bit exp_i;
        do_reset();
        dreq_val = 1'b1; ireq_val = 1'b1; memreq_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dreq_msg = 67'h100 + REQ_W'(k);
            ireq_msg = 67'h200 + REQ_W'(k);
            exp_i = (k % 2) == 1;
            #1;
            n_checks++; if (dreq_rdy !== !exp_i || ireq_rdy !== exp_i) begin n_errors++; $display("FAIL rr_grant_%0d: got d=%0b i=%0b want %0b %0b", k, dreq_rdy, ireq_rdy, !exp_i, exp_i); end
            n_checks++; if (memreq_msg !== (exp_i ? ireq_msg : dreq_msg)) begin n_errors++; $display("FAIL rr_msg_%0d: got %0h want %0h", k, memreq_msg, exp_i ? ireq_msg : dreq_msg); end
            advance();
        end
        dreq_val = 1'b0; ireq_val = 1'b0;
        memresp_val = 1'b1; dresp_rdy = 1'b1; iresp_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            memresp_msg = 47'hA0 + RESP_W'(k);
            exp_i = (k % 2) == 1;
            #1;
            n_checks++; if (dresp_val !== !exp_i || iresp_val !== exp_i) begin n_errors++; $display("FAIL rr_route_%0d: got d=%0b i=%0b want %0b %0b", k, dresp_val, iresp_val, !exp_i, exp_i); end
            advance();
        end
        memresp_val = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        ireq_val = 1'b1; ireq_msg = 67'h1234; memreq_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin dreq_val = 1'b1; dreq_msg = 67'h5678; end
            #1;
            n_checks++; if (memreq_val !== 1'b1 || memreq_msg !== 67'h1234) begin n_errors++; $display("FAIL lock_hold_%0d: got val=%0b msg=%0h want 1 1234", k, memreq_val, memreq_msg); end
            n_checks++; if (dreq_rdy !== 1'b0) begin n_errors++; $display("FAIL lock_dreq_rdy_%0d: got %0b want 0", k, dreq_rdy); end
            advance();
        end
        memreq_rdy = 1'b1;
        #1;
        n_checks++; if (ireq_rdy !== 1'b1 || dreq_rdy !== 1'b0 || memreq_msg !== 67'h1234) begin n_errors++; $display("FAIL lock_fire: got i=%0b d=%0b msg=%0h want 1 0 1234", ireq_rdy, dreq_rdy, memreq_msg); end
        advance();
        ireq_val = 1'b0;
        #1;
        n_checks++; if (dreq_rdy !== 1'b1 || memreq_msg !== 67'h5678) begin n_errors++; $display("FAIL lock_next_grant: got d=%0b msg=%0h want 1 5678", dreq_rdy, memreq_msg); end
        advance();
        dreq_val = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        dreq_val = 1'b1; memreq_rdy = 1'b1;
        for (int k = 0; k < MAX_OUTS; k++) begin
            dreq_msg = 67'h300 + REQ_W'(k);
            #1;
            n_checks++; if (dreq_rdy !== 1'b1) begin n_errors++; $display("FAIL full_fill_%0d: dreq_rdy got %0b want 1", k, dreq_rdy); end
            advance();
        end
        dreq_msg = 67'h3FF;
        #1;
        n_checks++; if (memreq_val !== 1'b0 || dreq_rdy !== 1'b0) begin n_errors++; $display("FAIL full_block: got val=%0b rdy=%0b want 0 0", memreq_val, dreq_rdy); end
        advance();
        memresp_val = 1'b1; dresp_rdy = 1'b1; memresp_msg = 47'h55;
        #1;
        n_checks++; if (memresp_rdy !== 1'b1 || dresp_val !== 1'b1) begin n_errors++; $display("FAIL full_resp: got rdy=%0b dval=%0b want 1 1", memresp_rdy, dresp_val); end
        n_checks++; if (memreq_val !== 1'b0 || dreq_rdy !== 1'b0) begin n_errors++; $display("FAIL full_no_bypass: got val=%0b rdy=%0b want 0 0", memreq_val, dreq_rdy); end
        advance();
        memresp_val = 1'b0;
        #1;
        n_checks++; if (memreq_val !== 1'b1 || dreq_rdy !== 1'b1) begin n_errors++; $display("FAIL full_resume: got val=%0b rdy=%0b want 1 1", memreq_val, dreq_rdy); end
        advance();
        dreq_val = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        memreq_rdy = 1'b1;
        dreq_val = 1'b1; dreq_msg = 67'h41;
        advance();
        dreq_val = 1'b0; ireq_val = 1'b1; ireq_msg = 67'h42;
        advance();
        ireq_val = 1'b0;
        reset = 1'b0;
        advance();
        reset = 1'b1; dresp_rdy = 1'b1; iresp_rdy = 1'b1;
        #1;
        n_checks++; if (memresp_rdy !== 1'b0 || dresp_val !== 1'b0 || iresp_val !== 1'b0) begin n_errors++; $display("FAIL midrst_cleared: got rdy=%0b d=%0b i=%0b want 0 0 0", memresp_rdy, dresp_val, iresp_val); end
        ireq_val = 1'b1; ireq_msg = 67'h43;
        advance();
        ireq_val = 1'b0; memresp_val = 1'b1; memresp_msg = 47'h77;
        #1;
        n_checks++; if (iresp_val !== 1'b1 || dresp_val !== 1'b0 || iresp_msg !== 47'h77) begin n_errors++; $display("FAIL midrst_route: got i=%0b d=%0b msg=%0h want 1 0 77", iresp_val, dresp_val, iresp_msg); end
        advance();
        memresp_val = 1'b0;
    endtask

    task automatic test_random_wrap();
        bit pend_d, pend_i, drain;
        int d_req_n, i_req_n, d_resp_n, i_resp_n;
        logic [95:0] r96;
        logic [63:0] r64;
        logic [REQ_W-1:0] exp_msg;
        do_reset();
        pend_d = 1'b0; pend_i = 1'b0;
        d_req_n = 0; i_req_n = 0; d_resp_n = 0; i_resp_n = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            drain = (cyc >= 500);
            if (drain && !pend_d && !pend_i && tags.size() == 0) break;
            if (!drain && !pend_d && $urandom_range(99, 0) < 55) begin
                pend_d = 1'b1; r96 = {$urandom(), $urandom(), $urandom()}; dreq_msg = r96[REQ_W-1:0];
            end
            if (!drain && !pend_i && $urandom_range(99, 0) < 55) begin
                pend_i = 1'b1; r96 = {$urandom(), $urandom(), $urandom()}; ireq_msg = r96[REQ_W-1:0];
            end
            dreq_val = pend_d; ireq_val = pend_i;
            memreq_rdy = drain || ($urandom_range(99, 0) < 70);
            memresp_val = (tags.size() > 0) && (drain || ($urandom_range(99, 0) < 60));
            r64 = {$urandom(), $urandom()}; memresp_msg = r64[RESP_W-1:0];
            dresp_rdy = drain || ($urandom_range(99, 0) < 75);
            iresp_rdy = drain || ($urandom_range(99, 0) < 45);
            #1;
            model_eval();
            exp_msg = e_gid ? ireq_msg : dreq_msg;
            n_checks++; if (memreq_val !== e_memreq_val) begin n_errors++; $display("FAIL rnd_memreq_val c%0d: got %0b want %0b", cyc, memreq_val, e_memreq_val); end
            if (e_memreq_val) begin
                n_checks++; if (memreq_msg !== exp_msg) begin n_errors++; $display("FAIL rnd_memreq_msg c%0d: got %0h want %0h", cyc, memreq_msg, exp_msg); end
            end
            n_checks++; if (dreq_rdy !== e_drdy || ireq_rdy !== e_irdy) begin n_errors++; $display("FAIL rnd_req_rdy c%0d: got d=%0b i=%0b want %0b %0b", cyc, dreq_rdy, ireq_rdy, e_drdy, e_irdy); end
            n_checks++; if (memresp_rdy !== e_memresp_rdy) begin n_errors++; $display("FAIL rnd_memresp_rdy c%0d: got %0b want %0b", cyc, memresp_rdy, e_memresp_rdy); end
            n_checks++; if (dresp_val !== e_dv || iresp_val !== e_iv) begin n_errors++; $display("FAIL rnd_resp_val c%0d: got d=%0b i=%0b want %0b %0b", cyc, dresp_val, iresp_val, e_dv, e_iv); end
            n_checks++; if (dresp_msg !== memresp_msg || iresp_msg !== memresp_msg) begin n_errors++; $display("FAIL rnd_resp_msg c%0d: got d=%0h i=%0h want %0h", cyc, dresp_msg, iresp_msg, memresp_msg); end
            if (dresp_val === 1'b1 && dresp_rdy) d_resp_n++;
            if (iresp_val === 1'b1 && iresp_rdy) i_resp_n++;
            advance();
            if (last_req_fire) begin
                if (last_gid) begin pend_i = 1'b0; i_req_n++; end
                else begin pend_d = 1'b0; d_req_n++; end
            end
        end
        idle_inputs();
        n_checks++; if (pend_d || pend_i || tags.size() != 0) begin n_errors++; $display("FAIL rnd_drain: pending d=%0b i=%0b outstanding=%0d want 0 0 0", pend_d, pend_i, tags.size()); end
        n_checks++; if (d_resp_n != d_req_n || i_resp_n != i_req_n) begin n_errors++; $display("FAIL rnd_totals: got resp d=%0d i=%0d want d=%0d i=%0d", d_resp_n, i_resp_n, d_req_n, i_req_n); end
        n_checks++; if (d_req_n < 20 || i_req_n < 20) begin n_errors++; $display("FAIL rnd_traffic: got d=%0d i=%0d requests want at least 20 each", d_req_n, i_req_n); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_port();
        test_round_robin();
        test_lock();
        test_full();
        test_reset_mid();
        test_random_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/proc_mem_arbiter.md
# proc_mem_arbiter

Two-requester memory arbiter that lets the pipelined processor's instruction-fetch port and data port share one memory request/response interface. Requests are merged with round-robin priority. A small in-order tag FIFO records which requester owns each outstanding request, so responses are routed back without any tag field in the message. The block sits between the processor's imem/dmem val/rdy ports and a single cache or test memory port.

## Interface
- REQ_W, default 67: request message width (opaque, passed through unchanged).
- RESP_W, default 47: response message width (opaque, passed through unchanged).
- MAX_OUTS, default 4: maximum number of outstanding requests; tag FIFO depth; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; state clears on a rising clk edge while reset=0.
- dreq_val / dreq_rdy / dreq_msg  in / out / in  1 / 1 / REQ_W  data-side request (requester 0).
- ireq_val / ireq_rdy / ireq_msg  in / out / in  1 / 1 / REQ_W  instruction-side request (requester 1).
- memreq_val / memreq_rdy / memreq_msg  out / in / out  1 / 1 / REQ_W  merged request to memory.
- memresp_val / memresp_rdy / memresp_msg  in / out / in  1 / 1 / RESP_W  response from memory; responses arrive in request order.
- dresp_val / dresp_rdy / dresp_msg  out / in / out  1 / 1 / RESP_W  data-side response.
- iresp_val / iresp_rdy / iresp_msg  out / in / out  1 / 1 / RESP_W  instruction-side response.

## Operation
- Handshake: a transfer fires on any val/rdy pair in a cycle where both are 1.
- State:
  - prio: 1 bit; 0 = data port favoured.
  - lock_v, lock_id: grant hold.
  - Tag FIFO: MAX_OUTS entries of 1-bit requester ID, with head pointer, tail pointer and a count of width log2(MAX_OUTS)+1.
- Grant selection:
  - If lock_v=1, grant = lock_id.
  - Otherwise, if exactly one of dreq_val/ireq_val is 1, grant that port.
  - Otherwise, if both are 1, grant the port favoured by prio.
  - If neither is 1, there is no grant.
- Request path:
  - memreq_val = granted port's val AND (count < MAX_OUTS).
  - memreq_msg = granted port's msg.
  - Granted port's rdy = memreq_rdy AND (count < MAX_OUTS).
  - Ungranted port's rdy = 0.
- Lock: if memreq_val=1 and memreq_rdy=0, set lock_v=1 and lock_id=grant. Clear lock_v on memreq fire. This keeps memreq_msg stable until it is accepted.
- Priority update: on memreq fire, prio is set to favour the port that was not granted.
- Tag FIFO:
  - Push the granted ID on memreq fire.
  - Pop on memresp fire.
  - Simultaneous push and pop: pointers both advance and count is unchanged.
  - Full (count = MAX_OUTS) blocks requests. There is no same-cycle bypass from pop to push.
  - Pointers wrap modulo MAX_OUTS.
- Response path:
  - If count=0: dresp_val=iresp_val=0 and memresp_rdy=0.
  - Otherwise, head ID selects the destination. Destination val = memresp_val, destination msg = memresp_msg, memresp_rdy = destination rdy.
  - The non-destination port has val=0.
  - Both resp_msg outputs always carry memresp_msg.
- Error: memresp_val=1 while count=0 triggers a simulation assertion failure. No hardware state change occurs.

## Timing
- Zero-cycle combinational pass-through on both request and response paths; no added latency.
- Paths rdy→rdy and val→val are combinational. No path exists from memresp to memreq in the same cycle.
- Reset values: prio=0, lock_v=0, count=0, head=tail=0.
- Outputs during and immediately after reset: memreq_val=0, dreq_rdy=ireq_rdy=0 unless a val is present, memresp_rdy=0, dresp_val=iresp_val=0.
- Reset mid-operation discards all outstanding tags. The environment must also discard in-flight memory responses.
- Sustained throughput is one request and one response per cycle when count < MAX_OUTS.

## Test plan
- Single port, no contention:
  - Stimulus: dreq_val=1 with msg 0x11 in cycle 1, memreq_rdy=1; memory returns resp 0xAA one cycle later with dresp_rdy=1.
  - Required: memreq_msg=0x11 in cycle 1; dresp_val=1 with msg 0xAA; iresp_val=0 throughout; count returns to 0.
- Round-robin:
  - Stimulus: both vals held high for 4 cycles, memreq_rdy=1.
  - Required: grant sequence D, I, D, I; each port's rdy asserted alternately.
- Lock under backpressure:
  - Stimulus: ireq_val=1 granted with memreq_rdy=0 for 3 cycles while dreq_val rises in cycle 2.
  - Required: memreq_msg remains the instruction message all 3 cycles; dreq_rdy=0; data port is granted on the cycle after the fire.
- Full FIFO:
  - Stimulus: MAX_OUTS=4; issue 4 requests with no responses.
  - Required: on the 5th request memreq_val=0 and requester rdy=0. In the cycle a response fires, the request is still blocked; it fires on the next cycle.
- Routing with wrap-around:
  - Stimulus: 10 interleaved D/I requests with responses trickling in, so pointers wrap.
  - Required: each response goes to the matching port in order. Stalling iresp_rdy=0 holds memresp_rdy=0 without losing data.
- Reset mid-operation:
  - Stimulus: reset=0 for one cycle with 2 requests outstanding.
  - Required: count=0 and all resp vals 0 afterward; a fresh request is routed correctly.
